// File: rtl/queue_command_if.sv
// Command-to-queue bus: strobes and data toward the queue, status flags back.
interface queue_command_if #(
  parameter int N = 4
);
  logic         full;
  logic         empty;
  logic         en_in;
  logic         en_out;
  logic [N-1:0] data;
  logic         reject;
  logic [7:0]   op_count;

  // The command stage drives strobes/data and watches the queue flags.
  modport master (
    input  full,
    input  empty,
    output en_in,
    output en_out,
    output data,
    output reject,
    output op_count
  );

  // The queue side sees the strobes and reports its flags.
  modport slave (
    output full,
    output empty,
    input  en_in,
    input  en_out,
    input  data,
    input  reject,
    input  op_count
  );
endinterface

// File: rtl/queue_command.sv
// Queue command stage: synchronises and debounces two push-buttons, turns
// button presses into single-cycle enqueue/dequeue strobes, and refuses
// requests the queue cannot take (or that arrive together).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a debounced press event
// ISSUE_IN  | en_in high for this one cycle, data stable
// ISSUE_OUT | en_out high for this one cycle
// REJECT    | reject high for this one cycle
// WAIT_REL  | waiting for both debounced buttons to be released
module queue_command #(
  parameter int N  = 4,
  parameter int DB = 16
) (
  input  logic          CLK100MHZ,
  input  logic          reset,
  input  logic          btn_in,
  input  logic          btn_out,
  input  logic [N-1:0]  sw,
  queue_command_if.master q
);
  localparam int CW = $clog2(DB + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_IN,
    ISSUE_OUT,
    REJECT,
    WAIT_REL
  } state_t;

  // Index 0 is the enqueue button, index 1 the dequeue button.
  logic [1:0]    sync1_d, sync1_q;
  logic [1:0]    sync2_d, sync2_q;
  logic [1:0]    st_d, st_q;
  logic [1:0]    st_prev_d, st_prev_q;
  logic [CW-1:0] cnt_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    press;

  state_t        state_d, state_q;
  logic          en_in_d, en_in_q;
  logic          en_out_d, en_out_q;
  logic          reject_d, reject_q;
  logic [N-1:0]  data_d, data_q;
  logic [7:0]    op_count_d, op_count_q;

  // Two-flop synchroniser and edge-history next values.
  always_comb begin
    sync1_d   = {btn_out, btn_in};
    sync2_d   = sync1_q;
    st_prev_d = st_q;
  end

  // Debouncer: the stable level flips only after DB consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != st_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          st_d[i] = ~st_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A press is a rising edge of the debounced level; releases are ignored.
  always_comb begin
    press = st_q & ~st_prev_q;
  end

  // Next-state and registered-output logic; flags are looked at only on a press in IDLE.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: begin
        if (press[0] && press[1]) begin
          state_d = REJECT;
        end else if (press[0]) begin
          if (q.full) begin
            state_d = REJECT;
          end else begin
            state_d = ISSUE_IN;
            data_d  = sw;
          end
        end else if (press[1]) begin
          state_d = q.empty ? REJECT : ISSUE_OUT;
        end
      end
      ISSUE_IN, ISSUE_OUT: begin
        op_count_d = op_count_q + 8'd1;
        state_d    = WAIT_REL;
      end
      REJECT: begin
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (st_q == 2'b00) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    en_in_d  = (state_d == ISSUE_IN);
    en_out_d = (state_d == ISSUE_OUT);
    reject_d = (state_d == REJECT);
  end

  // All state and outputs clear immediately on reset, even mid-strobe.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      st_q       <= '0;
      st_prev_q  <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      state_q    <= IDLE;
      en_in_q    <= 1'b0;
      en_out_q   <= 1'b0;
      reject_q   <= 1'b0;
      data_q     <= '0;
      op_count_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      st_q       <= st_d;
      st_prev_q  <= st_prev_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      state_q    <= state_d;
      en_in_q    <= en_in_d;
      en_out_q   <= en_out_d;
      reject_q   <= reject_d;
      data_q     <= data_d;
      op_count_q <= op_count_d;
    end
  end

  assign q.en_in    = en_in_q;
  assign q.en_out   = en_out_q;
  assign q.reject   = reject_q;
  assign q.data     = data_q;
  assign q.op_count = op_count_q;
endmodule

// File: tb/tb_queue_command.sv
// Bench for queue_command: directed button scenarios, a behavioural model
// checked every cycle, and literal expectations for each scenario.
module tb_queue_command;
  localparam int N  = 4;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         btn_in = 1'b0;
  logic         btn_out = 1'b0;
  logic [N-1:0] sw = '0;

  queue_command_if #(.N(N)) qif ();

  queue_command #(.N(N), .DB(DB)) dut (
    .CLK100MHZ (clk),
    .reset     (rst_n),
    .btn_in    (btn_in),
    .btn_out   (btn_out),
    .sw        (sw),
    .q         (qif.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounced level = flips once the last DB synchronised samples all disagree
  // with it. Requests are accepted only when not busy; busy lasts from the
  // strobe until both debounced levels are low again.
  bit           m_en_in, m_en_out, m_rej, m_busy;
  logic [N-1:0] m_data;
  logic [7:0]   m_ops;
  bit           m_r1   [2];
  bit           m_s    [2];
  bit           m_st   [2];
  bit           m_prev [2];
  bit           m_hist [2][DB];

  always @(posedge clk or negedge rst_n) begin
    bit ev [2];
    bit raw [2];
    bit strobing, all_diff, n_in, n_out, n_rej;
    if (!rst_n) begin
      m_en_in = 0; m_en_out = 0; m_rej = 0; m_busy = 0;
      m_data = '0; m_ops = '0;
      for (int i = 0; i < 2; i++) begin
        m_r1[i] = 0; m_s[i] = 0; m_st[i] = 0; m_prev[i] = 0;
        for (int j = 0; j < DB; j++) m_hist[i][j] = 0;
      end
    end else begin
      raw[0] = btn_in;
      raw[1] = btn_out;
      for (int i = 0; i < 2; i++) ev[i] = m_st[i] && !m_prev[i];
      strobing = m_en_in || m_en_out || m_rej;
      if (m_en_in || m_en_out) m_ops = m_ops + 8'd1;
      n_in = 0; n_out = 0; n_rej = 0;
      if (!m_busy) begin
        if (ev[0] && ev[1]) n_rej = 1;
        else if (ev[0]) begin
          if (qif.full) n_rej = 1;
          else begin n_in = 1; m_data = sw; end
        end else if (ev[1]) begin
          if (qif.empty) n_rej = 1;
          else n_out = 1;
        end
        m_busy = n_in || n_out || n_rej;
      end else if (!strobing && !m_st[0] && !m_st[1]) begin
        m_busy = 0;
      end
      m_en_in = n_in; m_en_out = n_out; m_rej = n_rej;
      for (int i = 0; i < 2; i++) begin
        m_prev[i] = m_st[i];
        for (int j = DB - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
        m_hist[i][0] = m_s[i];
        all_diff = 1;
        for (int j = 0; j < DB; j++) if (m_hist[i][j] == m_st[i]) all_diff = 0;
        if (all_diff) m_st[i] = !m_st[i];
        m_s[i]  = m_r1[i];
        m_r1[i] = raw[i];
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("en_in", 32'(qif.en_in), 32'(m_en_in));
      chk("en_out", 32'(qif.en_out), 32'(m_en_out));
      chk("reject", 32'(qif.reject), 32'(m_rej));
      chk("data", 32'(qif.data), 32'(m_data));
      chk("op_count", 32'(qif.op_count), 32'(m_ops));
      chk("one_hot", 32'(32'(qif.en_in) + 32'(qif.en_out) + 32'(qif.reject) <= 1), 32'd1);
    end
  end

  // Strobe tallies for the scenario-level literal checks.
  int n_en_in, n_en_out, n_rej, first_in_cyc;
  always @(negedge clk) begin
    if (rst_n) begin
      if (qif.en_in) begin
        if (n_en_in == 0) first_in_cyc = cyc;
        n_en_in++;
      end
      if (qif.en_out) n_en_out++;
      if (qif.reject) n_rej++;
    end
  end

  task automatic clear_counts();
    n_en_in = 0; n_en_out = 0; n_rej = 0; first_in_cyc = -1;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input bit b_in, input bit b_out, input int hold, input int gap);
    btn_in = b_in; btn_out = b_out;
    step(hold);
    btn_in = 0; btn_out = 0;
    step(gap);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_en_in"}, 32'(qif.en_in), 32'd0);
    chk({tag, "_en_out"}, 32'(qif.en_out), 32'd0);
    chk({tag, "_reject"}, 32'(qif.reject), 32'd0);
    chk({tag, "_data"}, 32'(qif.data), 32'd0);
    chk({tag, "_op_count"}, 32'(qif.op_count), 32'd0);
  endtask

  initial begin
    int c;
    bit found;
    qif.full = 0;
    qif.empty = 1;
    clear_counts();

    // Reset state
    step(3);
    check_reset_values("rst");
    rst_n = 1;
    step(2);

    // Clean enqueue: strobe 2+DB edges after the first sample, i.e. 7 cycles after driving
    sw = 4'hA;
    clear_counts();
    btn_in = 1;
    c = cyc;
    step(20);
    btn_in = 0;
    step(DB + 8);
    chk("clean_n_en_in", 32'(n_en_in), 32'd1);
    chk("clean_latency", 32'(first_in_cyc - c), 32'd7);
    chk("clean_others", 32'(n_en_out + n_rej), 32'd0);
    chk("clean_data", 32'(qif.data), 32'hA);
    chk("clean_op_count", 32'(qif.op_count), 32'd1);
    chk("model_ops_pin", 32'(m_ops), 32'd1);

    // Bounce: 2-cycle toggles never reach DB=4 consecutive samples
    qif.empty = 0;
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      btn_out = ~btn_out;
      step(2);
    end
    chk("bounce_quiet", 32'(n_en_out + n_en_in + n_rej), 32'd0);
    btn_out = 1;
    step(20);
    btn_out = 0;
    step(DB + 8);
    chk("bounce_n_en_out", 32'(n_en_out), 32'd1);
    chk("bounce_op_count", 32'(qif.op_count), 32'd2);

    // Full reject
    qif.full = 1;
    clear_counts();
    press(1, 0, 15, DB + 8);
    chk("full_rej", 32'(n_rej), 32'd1);
    chk("full_no_en_in", 32'(n_en_in), 32'd0);
    chk("full_op_count", 32'(qif.op_count), 32'd2);
    qif.full = 0;

    // Empty reject
    qif.empty = 1;
    clear_counts();
    press(0, 1, 15, DB + 8);
    chk("empty_rej", 32'(n_rej), 32'd1);
    chk("empty_no_en_out", 32'(n_en_out), 32'd0);
    chk("empty_op_count", 32'(qif.op_count), 32'd2);
    qif.empty = 0;

    // Simultaneous press, then a re-press while the other button is still held
    clear_counts();
    btn_in = 1; btn_out = 1;
    step(15);
    chk("simul_rej", 32'(n_rej), 32'd1);
    btn_out = 0;
    step(DB + 6);
    btn_out = 1;
    step(15);
    btn_in = 0; btn_out = 0;
    step(DB + 8);
    chk("simul_rej_total", 32'(n_rej), 32'd1);
    chk("simul_no_issue", 32'(n_en_in + n_en_out), 32'd0);
    chk("simul_op_count", 32'(qif.op_count), 32'd2);

    // Reset during the ISSUE_IN cycle, release with the button still held
    sw = 4'h5;
    clear_counts();
    btn_in = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1);
      if (qif.en_in) found = 1;
    end
    chk("midrst_reach_issue", 32'(found), 32'd1);
    rst_n = 0;
    #1;
    check_reset_values("midrst");
    step(3);
    clear_counts();
    rst_n = 1;
    c = cyc;
    step(20);
    chk("midrst_n_en_in", 32'(n_en_in), 32'd1);
    chk("midrst_latency", 32'(first_in_cyc - c), 32'(DB + 3));
    chk("midrst_data", 32'(qif.data), 32'h5);
    chk("midrst_op_count", 32'(qif.op_count), 32'd1);
    btn_in = 0;
    step(DB + 8);

    // Counter wrap: 256 accepted alternating operations from a fresh reset
    rst_n = 0;
    step(2);
    rst_n = 1;
    step(2);
    clear_counts();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) chk("wrap_pre_count", 32'(qif.op_count), 32'd255);
      sw = 4'(i);
      if (i % 2 == 0) press(1, 0, DB + 8, DB + 8);
      else press(0, 1, DB + 8, DB + 8);
    end
    chk("wrap_n_en_in", 32'(n_en_in), 32'd128);
    chk("wrap_n_en_out", 32'(n_en_out), 32'd128);
    chk("wrap_rej", 32'(n_rej), 32'd0);
    chk("wrap_op_count", 32'(qif.op_count), 32'd0);
    chk("wrap_data", 32'(qif.data), 32'hE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit, got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/queue_command.md
# queue_command

Upstream command stage for the queue: turns two raw push-buttons and a data switch bank into clean, single-cycle enqueue/dequeue strobes. It synchronises and debounces the buttons, detects presses, and checks each request against the queue's `full`/`empty` flags. Accepted requests are issued one at a time with the data held stable. It runs on the same clock as the queue and drives the queue's `en_in`/`en_out`/`in` inputs directly.

## Interface
- `N`, 4: data width, equal to the queue data width.
- `DB`, 16: debounce length in clock cycles; must be ≥ 2.
- `CLK100MHZ` in 1: clock; the same clock that samples the queue.
- `reset` in 1: asynchronous, active-low reset.
- `btn_in` in 1: raw enqueue button, asynchronous, bouncy.
- `btn_out` in 1: raw dequeue button, asynchronous, bouncy.
- `sw` in N: enqueue data switches, quasi-static.
- `full` in 1: queue full flag.
- `empty` in 1: queue empty flag.
- `en_in` out 1: one-cycle enqueue strobe.
- `en_out` out 1: one-cycle dequeue strobe.
- `data` out N: enqueue data, valid while `en_in` is high.
- `reject` out 1: one-cycle strobe for a refused request.
- `op_count` out 8: count of issued operations, wraps modulo 256.

## Operation
- **Synchroniser:** each button passes through a 2-flop synchroniser, giving `s_in`/`s_out`.
- **Debouncer:** one per button.
  - The stable level `st` starts at 0.
  - Counter `cnt`, width ceil(log2(DB+1)), increments each cycle that the synced level differs from `st`.
  - When the synced level equals `st`, `cnt` clears to 0.
  - When `cnt` would reach DB, `st` toggles and `cnt` clears.
- **Press event:** `st` rising, where `st`=1 and its previous-cycle value was 0. A release produces no event.
- **FSM states:** IDLE, ISSUE_IN, ISSUE_OUT, REJECT, WAIT_REL. Encoding is free. All outputs are registered.
- **IDLE transitions:**
  - Both press events in the same cycle → REJECT (the queue XORs enables, so a simultaneous request is illegal).
  - In-press only: `full`=1 → REJECT; otherwise → ISSUE_IN and latch `data` <= `sw`.
  - Out-press only: `empty`=1 → REJECT; otherwise → ISSUE_OUT.
  - No event → stay in IDLE.
- **ISSUE_IN:** `en_in`=1 for exactly this cycle; `op_count`++ at the end of the cycle; → WAIT_REL.
- **ISSUE_OUT:** `en_out`=1 for exactly this cycle; `op_count`++; → WAIT_REL.
- **REJECT:** `reject`=1 for exactly this cycle; `op_count` unchanged; → WAIT_REL.
- **WAIT_REL:** stay until both debounced levels are 0, then → IDLE. Press events occurring in any state other than IDLE are discarded.
- `en_in`, `en_out` and `reject` are mutually exclusive; at most one is high in any cycle.
- `data` holds its last latched value outside ISSUE_IN. It changes only on an IDLE→ISSUE_IN transition.
- `full`/`empty` are sampled only in the IDLE cycle that sees the press event.

## Timing
- **Reset values:**
  - State IDLE.
  - `en_in`=0, `en_out`=0, `reject`=0, `data`=0, `op_count`=0.
  - Both `st`=0, both `cnt`=0, synchronisers 0.
- Reset assertion clears everything immediately, including mid-strobe. No strobe is generated on reset release, even if a button is held. A held button is seen as a press only after `st` rises, i.e. DB cycles after release of reset plus sync.
- **Latency:** raw button high and clean before edge k; synced level high after edge k+1; `st` rises at edge k+1+DB. The FSM leaves IDLE at edge k+2+DB, so the strobe is high during the cycle following edge k+2+DB.
- A bounce shorter than DB cycles never changes `st`.
- Minimum spacing between two strobes is 2·DB+O(1) cycles: release debounce plus press debounce.
- `op_count` wraps 255→0 with no flag.

## Test plan
- **Clean enqueue:** DB=4, `sw`=4'hA, `full`=0, `btn_in` held high 20 cycles → exactly one `en_in` pulse, starting 6 cycles after the first high sample; `data`=4'hA during the pulse; `op_count`=1.
- **Bounce:** DB=4, `btn_out` toggles every 2 cycles for 20 cycles then holds high, `empty`=0 → exactly one `en_out`; no strobe during the bounce window.
- **Full/empty reject:**
  - `full`=1, press `btn_in` → `reject` pulse, no `en_in`, `op_count` unchanged.
  - `empty`=1, press `btn_out` → same result.
- **Simultaneous press:** both buttons rise on the same cycle → one `reject`; no `en_in`/`en_out`. A second press while both are still held produces nothing.
- **Reset mid-operation:** assert `reset`=0 during the ISSUE_IN cycle → `en_in` drops immediately and all outputs reach their reset values. Deassert with `btn_in` still held → exactly one `en_in`, no earlier than DB+3 cycles after release.
- **Counter wrap:** 256 accepted alternating enqueue/dequeue operations → `op_count` returns to 0.
